// File: rtl/arb_merge_rr_mmu_pkg.sv
// Shared constants and helpers for the per-port buffered merge arbiter.
package arb_merge_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Width of a port index; a single-port build still gets a 1-bit id.
    function automatic int pid_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/arb_merge_rr_mmu_if.sv
// Bundle of the N-input / 1-output handshake signals of the merge arbiter.
interface arb_merge_rr_mmu_if #(
    parameter int NUM_PORTS  = 8,
    parameter int DATA_WIDTH = 88
) ();
    import arb_merge_pkg::*;

    localparam int PW = pid_width(NUM_PORTS);

    // Valid/ready: a word moves on a rising edge where valid and ready are both
    // high; valid never waits on ready, and ready (o_free) is registered-only.
    logic [NUM_PORTS-1:0]            i_drive;
    logic [NUM_PORTS*DATA_WIDTH-1:0] i_data;
    logic [NUM_PORTS-1:0]            o_free;
    logic                            o_driveNext;
    logic [DATA_WIDTH-1:0]           o_data;
    logic [PW-1:0]                   o_portId;
    logic                            i_freeNext;

    modport master (
        output i_drive, i_data, i_freeNext,
        input  o_free, o_driveNext, o_data, o_portId
    );

    modport slave (
        input  i_drive, i_data, i_freeNext,
        output o_free, o_driveNext, o_data, o_portId
    );

endinterface

// File: rtl/arb_merge_rr_mmu_fifo.sv
// Per-port synchronous FIFO; depth must be a power of two so pointers wrap naturally.
module sync_fifo_mmu #(
    parameter int DATA_WIDTH = 88,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/arb_merge_rr_mmu.sv
// Merges NUM_PORTS buffered input channels into one registered output stream
// using fixed-priority or round-robin arbitration.
module arb_merge_rr_mmu
    import arb_merge_pkg::*;
#(
    parameter int NUM_PORTS  = 8,
    parameter int DATA_WIDTH = 88,
    parameter int FIFO_DEPTH = 2,
    parameter int ARB_MODE   = ARB_RR
) (
    input logic               clk,
    input logic               rst,
    arb_merge_rr_mmu_if.slave bus
);
    localparam int PW = pid_width(NUM_PORTS);
    localparam int IW = PW + 1;

    logic [NUM_PORTS-1:0]  full, empty, free, push, pop;
    logic [DATA_WIDTH-1:0] head [NUM_PORTS];
    logic                  load_en, grant_valid;
    logic [PW-1:0]         grant_id;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PW-1:0]         pid_q, pid_d;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        sync_fifo_mmu #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (push[i]),
            .pop  (pop[i]),
            .din  (bus.i_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .full (full[i]),
            .empty(empty[i]),
            .head (head[i])
        );
    end

    // Ready depends only on registered occupancy, so a full port stays closed
    // even on the edge its head is popped.
    assign free    = ~full & {NUM_PORTS{~rst}};
    assign push    = bus.i_drive & free;
    assign load_en = ~valid_q | bus.i_freeNext;

    // Walk downward so the candidate closest to the search start wins.
    always_comb begin
        logic [IW-1:0] idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            idx = ((ARB_MODE == ARB_RR) ? {1'b0, rr_ptr_q} : IW'(0)) + IW'(j);
            if (idx >= IW'(NUM_PORTS)) idx = idx - IW'(NUM_PORTS);
            if (!empty[idx[PW-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (load_en && grant_valid) pop[grant_id] = 1'b1;
    end

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        pid_d    = pid_q;
        rr_ptr_d = rr_ptr_q;
        if (load_en) begin
            valid_d = grant_valid;
            if (grant_valid) begin
                data_d = head[grant_id];
                pid_d  = grant_id;
                if (ARB_MODE == ARB_RR) begin
                    rr_ptr_d = (grant_id == PW'(NUM_PORTS - 1)) ? '0 : grant_id + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            pid_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            pid_q    <= pid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.o_free      = free;
    assign bus.o_driveNext = valid_q;
    assign bus.o_data      = data_q;
    assign bus.o_portId    = pid_q;

endmodule

// File: tb/tb_arb_merge_rr_mmu.sv
// Bench for arb_merge_rr_mmu: a fixed-priority and a round-robin instance share
// one stimulus stream and are checked against a queue-based model every cycle.
module tb_arb_merge_rr_mmu;
    import arb_merge_pkg::*;

    localparam int NP = 8;
    localparam int DW = 88;
    localparam int FD = 2;
    localparam int PW = 3;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    drive;
    logic [NP*DW-1:0] data_flat;
    logic             free_next;
    int               checks = 0;
    int               errors = 0;

    // ---------------- clock / DUTs ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    arb_merge_rr_mmu_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus0 ();
    arb_merge_rr_mmu_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.i_drive    = drive;
    assign bus0.i_data     = data_flat;
    assign bus0.i_freeNext = free_next;
    assign bus1.i_drive    = drive;
    assign bus1.i_data     = data_flat;
    assign bus1.i_freeNext = free_next;

    arb_merge_rr_mmu #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ARB_MODE(ARB_FIXED))
        u_dut_fixed (.clk(clk), .rst(rst), .bus(bus0));
    arb_merge_rr_mmu #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ARB_MODE(ARB_RR))
        u_dut_rr (.clk(clk), .rst(rst), .bus(bus1));

    // index 0 = fixed priority, index 1 = round robin
    logic [NP-1:0] d_free  [2];
    logic          d_valid [2];
    logic [DW-1:0] d_data  [2];
    logic [PW-1:0] d_pid   [2];
    assign d_free[0]  = bus0.o_free;
    assign d_valid[0] = bus0.o_driveNext;
    assign d_data[0]  = bus0.o_data;
    assign d_pid[0]   = bus0.o_portId;
    assign d_free[1]  = bus1.o_free;
    assign d_valid[1] = bus1.o_driveNext;
    assign d_data[1]  = bus1.o_data;
    assign d_pid[1]   = bus1.o_portId;

    // ---------------- checker ----------------
    task automatic chk(input string name, input int m, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [dut%0d] t=%0t: got %0h expected %0h", name, m, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] exp_q [2*NP][$];
    logic          m_valid  [2];
    logic [DW-1:0] m_data   [2];
    logic [PW-1:0] m_pid    [2];
    int            m_rr     [2];
    logic          m_loaded [2];
    logic [NP-1:0] m_pend   [2];
    int            since    [NP];

    task automatic model_reset(input int m);
        for (int i = 0; i < NP; i++) exp_q[m*NP+i].delete();
        m_valid[m]  = 1'b0;
        m_data[m]   = '0;
        m_pid[m]    = '0;
        m_rr[m]     = 0;
        m_loaded[m] = 1'b0;
        m_pend[m]   = '0;
    endtask

    task automatic model_step(input int m);
        logic          ld;
        int            g;
        logic [NP-1:0] can_push;
        ld = !m_valid[m] || free_next;
        g  = -1;
        for (int i = 0; i < NP; i++) begin
            m_pend[m][i] = (exp_q[m*NP+i].size() > 0);
            can_push[i]  = drive[i] && (exp_q[m*NP+i].size() < FD);
        end
        if (ld) begin
            for (int j = 0; j < NP; j++) begin
                int k;
                k = (m == 1) ? (m_rr[m] + j) % NP : j;
                if (g < 0 && m_pend[m][k]) g = k;
            end
            if (g >= 0) begin
                m_data[m]  = exp_q[m*NP+g].pop_front();
                m_pid[m]   = PW'(g);
                m_valid[m] = 1'b1;
                if (m == 1) m_rr[m] = (g + 1) % NP;
            end else begin
                m_valid[m] = 1'b0;
            end
        end
        m_loaded[m] = ld && (g >= 0);
        for (int i = 0; i < NP; i++)
            if (can_push[i]) exp_q[m*NP+i].push_back(data_flat[i*DW +: DW]);
    endtask

    always @(posedge clk or posedge rst) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) model_reset(m);
            else     model_step(m);
        end
    end

    // ---------------- per-cycle compare + transfer log ----------------
    logic [PW-1:0] pid_log  [2][$];
    logic [DW-1:0] data_log [2][$];

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic [NP-1:0] ef;
            for (int i = 0; i < NP; i++) ef[i] = !rst && (exp_q[m*NP+i].size() < FD);
            chk("o_free", m, d_free[m], ef);
            chk("o_driveNext", m, d_valid[m], m_valid[m]);
            if (m_valid[m]) begin
                chk("o_data", m, d_data[m], m_data[m]);
                chk("o_portId", m, d_pid[m], m_pid[m]);
            end
            if (d_valid[m] && free_next) begin
                pid_log[m].push_back(d_pid[m]);
                data_log[m].push_back(d_data[m]);
            end
        end
        if (rst) begin
            for (int i = 0; i < NP; i++) since[i] = 0;
        end else if (m_loaded[1]) begin
            for (int i = 0; i < NP; i++) begin
                if (m_pend[1][i] && d_pid[1] != PW'(i)) begin
                    since[i]++;
                    chk("rr_bound", 1, since[i] < NP, 1'b1);
                end else begin
                    since[i] = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int            e_n;
    int            e_pid [2][8];
    logic [DW-1:0] e_dat [2][8];

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(1);
    endtask

    task automatic set_word(input int p, input logic [DW-1:0] v);
        data_flat[p*DW +: DW] = v;
    endtask

    task automatic clear_logs();
        for (int m = 0; m < 2; m++) begin
            pid_log[m].delete();
            data_log[m].delete();
        end
    endtask

    task automatic check_logs(input string name);
        for (int m = 0; m < 2; m++) begin
            chk({name, "_len"}, m, pid_log[m].size(), e_n);
            for (int i = 0; i < e_n && i < pid_log[m].size(); i++) begin
                chk({name, "_pid"}, m, pid_log[m][i], e_pid[m][i]);
                chk({name, "_data"}, m, data_log[m][i], e_dat[m][i]);
            end
        end
    endtask

    // ---------------- directed + soak stimulus ----------------
    initial begin
        rst       = 1'b1;
        drive     = '0;
        data_flat = '0;
        free_next = 1'b0;
        run(2);
        for (int m = 0; m < 2; m++) begin
            chk("rst_valid", m, d_valid[m], 1'b0);
            chk("rst_data", m, d_data[m], '0);
            chk("rst_pid", m, d_pid[m], '0);
            chk("rst_free", m, d_free[m], 8'h00);
        end
        rst = 1'b0;
        run(1);
        for (int m = 0; m < 2; m++) chk("free_after_rst", m, d_free[m], 8'hFF);

        // single word from port 3
        drive     = 8'b0000_1000;
        set_word(3, 88'h5A);
        free_next = 1'b1;
        run(1);
        drive = '0;
        run(1);
        for (int m = 0; m < 2; m++) begin
            chk("single_valid", m, d_valid[m], 1'b1);
            chk("single_data", m, d_data[m], 88'h5A);
            chk("single_pid", m, d_pid[m], 3'd3);
        end
        run(1);
        for (int m = 0; m < 2; m++) chk("single_done", m, d_valid[m], 1'b0);

        // ports 0,2,5 preloaded with two words each
        do_reset();
        free_next = 1'b0;
        drive     = 8'b0010_0101;
        set_word(0, 88'h100); set_word(2, 88'h120); set_word(5, 88'h150);
        run(1);
        set_word(0, 88'h101); set_word(2, 88'h121); set_word(5, 88'h151);
        run(1);
        drive = '0;
        clear_logs();
        free_next = 1'b1;
        run(8);
        e_n = 6;
        e_pid[0] = '{0, 0, 2, 2, 5, 5, 0, 0};
        e_dat[0] = '{88'h100, 88'h101, 88'h120, 88'h121, 88'h150, 88'h151, 88'h0, 88'h0};
        e_pid[1] = '{0, 2, 5, 0, 2, 5, 0, 0};
        e_dat[1] = '{88'h100, 88'h120, 88'h150, 88'h101, 88'h121, 88'h151, 88'h0, 88'h0};
        check_logs("seq025");

        // ports 1 and 6 preloaded with two words each
        do_reset();
        free_next = 1'b0;
        drive     = 8'b0100_0010;
        set_word(1, 88'h110); set_word(6, 88'h160);
        run(1);
        set_word(1, 88'h111); set_word(6, 88'h161);
        run(1);
        drive = '0;
        clear_logs();
        free_next = 1'b1;
        run(8);
        e_n = 4;
        e_pid[0] = '{1, 1, 6, 6, 0, 0, 0, 0};
        e_dat[0] = '{88'h110, 88'h111, 88'h160, 88'h161, 88'h0, 88'h0, 88'h0, 88'h0};
        e_pid[1] = '{1, 6, 1, 6, 0, 0, 0, 0};
        e_dat[1] = '{88'h110, 88'h160, 88'h111, 88'h161, 88'h0, 88'h0, 88'h0, 88'h0};
        check_logs("seq16");

        // backpressure: port 0 driven for 10 cycles with downstream stalled
        do_reset();
        free_next = 1'b0;
        drive     = 8'b0000_0001;
        for (int k = 0; k < 10; k++) begin
            set_word(0, 88'hA0 + 88'(k));
            run(1);
            if (k >= 1) begin
                for (int m = 0; m < 2; m++) begin
                    chk("bp_hold_valid", m, d_valid[m], 1'b1);
                    chk("bp_hold_data", m, d_data[m], 88'hA0);
                end
            end
        end
        for (int m = 0; m < 2; m++) chk("bp_free0", m, d_free[m][0], 1'b0);
        drive = '0;
        clear_logs();
        free_next = 1'b1;
        run(6);
        e_n = 3;
        for (int m = 0; m < 2; m++) begin
            e_pid[m] = '{0, 0, 0, 0, 0, 0, 0, 0};
            e_dat[m] = '{88'hA0, 88'hA1, 88'hA2, 88'h0, 88'h0, 88'h0, 88'h0, 88'h0};
        end
        check_logs("bp");

        // reset while every FIFO is full and the output is valid
        do_reset();
        free_next = 1'b0;
        drive     = '1;
        for (int p = 0; p < NP; p++) set_word(p, 88'h300 + 88'(p));
        run(4);
        for (int m = 0; m < 2; m++) begin
            chk("full_free", m, d_free[m], 8'h00);
            chk("full_valid", m, d_valid[m], 1'b1);
        end
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("midrst_valid", m, d_valid[m], 1'b0);
            chk("midrst_free", m, d_free[m], 8'h00);
            chk("midrst_data", m, d_data[m], '0);
            chk("midrst_pid", m, d_pid[m], '0);
        end
        run(1);
        rst       = 1'b0;
        drive     = '0;
        free_next = 1'b1;
        clear_logs();
        run(1);
        for (int m = 0; m < 2; m++) begin
            chk("postrst_free", m, d_free[m], 8'hFF);
            chk("postrst_valid", m, d_valid[m], 1'b0);
        end
        run(4);
        e_n = 0;
        check_logs("stale");

        // random soak with periodic long stalls
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            drive = NP'($urandom_range(0, (1 << NP) - 1));
            for (int p = 0; p < NP; p++) set_word(p, DW'({$urandom(), $urandom(), $urandom()}));
            free_next = ((c / 200) % 5 == 4) ? 1'b0 : ($urandom_range(0, 3) != 0);
            run(1);
        end
        drive     = '0;
        free_next = 1'b1;
        run(40);
        for (int m = 0; m < 2; m++) begin
            chk("drain_valid", m, d_valid[m], 1'b0);
            chk("drain_free", m, d_free[m], 8'hFF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
